dbg_emio_insig: RTL
===================

// Module: dbg_emio_insig
// PURPOSE
//   Debug stimulus source driven by the PS over EMIO GPIO. Software writes bytes
//   one at a time through from_gpio. The block buffers them in a FIFO and presents
//   them to the accelerator input as a valid/ready/last byte stream.
//   Status (level, flags, counters) is returned on to_gpio for software polling.
//   It is the input-side counterpart of the debug output-capture block.
// PARAMETERS
//   DEPTH   16  FIFO entries; power of two, 2..256
//   AW      4   log2(DEPTH); FIFO pointer width
// PORTS
//   clk        in   1   system clock
//   reset      in   1   asynchronous, active-high reset
//   from_gpio  in   64  [7:0] wdata, [8] wlast, [9] push strobe, [10] clear strobe,
//                       [11] hold; [63:12] ignored
//   to_gpio    out  64  status word; layout under BEHAVIOUR
//   in_data    out  8   stream data (FIFO head)
//   in_last    out  1   stream last flag (FIFO head)
//   in_valid   out  1   stream valid
//   in_ready   in   1   stream ready from the accelerator
// BEHAVIOUR
//   Input capture:
//   - g_q <= from_gpio every clk; g_q2 <= g_q.
//   - push_p  = g_q[9]  & ~g_q2[9]  (single-cycle pulse).
//   - clear_p = g_q[10] & ~g_q2[10] (single-cycle pulse).
//   - Software sets wdata/wlast before raising bit 9. The entry written is g_q[8:0].
//   FIFO:
//   - DEPTH x 9 bits; rd/wr pointers AW bits, wrapping at DEPTH.
//   - level is AW+1 bits, range 0..DEPTH.
//   - pop = in_valid & in_ready.
//   - push_p with level<DEPTH: write and increment wr_ptr.
//   - push_p with level==DEPTH and no pop that cycle: entry dropped, ovf <= 1 (sticky).
//   - push_p with level==DEPTH and pop that cycle: push accepted, level unchanged.
//   - Push and pop together at 0<level<DEPTH: level unchanged.
//   Clear:
//   - clear_p empties the FIFO (pointers and level -> 0) and clears ovf,
//     beat_cnt and frame_cnt.
//   - clear_p has priority over push_p and pop in the same cycle: neither takes
//     effect and nothing is counted. in_valid drops the following cycle, which is
//     an allowed protocol break for a debug flush.
//   Output state machine (registered in_valid):
//   - IDLE:    in_valid=0. Go to PRESENT when level>0 and g_q[11]==0.
//   - PRESENT: in_valid=1; in_data/in_last = head entry.
//       * Stay while in_ready==0. Head and valid stay stable; hold is ignored here.
//       * On pop with (level-1)>0 and hold==0, or with a push that cycle and
//         hold==0: stay in PRESENT with the next head, no bubble.
//       * Otherwise return to IDLE.
//   - Head is combinational from mem[rd_ptr]. The first entry appears on in_valid
//     2 clk after the edge that first samples from_gpio[9]=1.
//   Counters:
//   - beat_cnt (16b) increments on each pop.
//   - frame_cnt (16b) increments on each pop with in_last=1.
//   - Both wrap 0xFFFF -> 0.
//   to_gpio (registered, 1 clk behind internal state):
//   - [8:0]   level, zero-extended
//   - [9]     full (level==DEPTH)
//   - [10]    empty (level==0)
//   - [11]    ovf
//   - [12]    in_valid
//   - [15:13] 0
//   - [31:16] beat_cnt
//   - [47:32] frame_cnt
//   - [63:48] 0
//   Reset (async):
//   - g_q, g_q2, pointers, level, ovf and both counters -> 0; state IDLE.
//   - in_valid=0 and to_gpio=0x0000_0000_0000_0400 (empty=1). Memory is not reset.
//   - Reset mid-transfer discards all queued entries. A from_gpio[9] still high
//     after reset does not push (g_q2 reloads from g_q before any edge is seen).
// TESTING
//   - Reset: assert reset mid-burst -> in_valid=0, to_gpio=0x400 in the same cycle;
//     no push after release while bit9 stays 1.
//   - Single beat: wdata=0xA5, wlast=1, toggle bit9 with in_ready=1 ->
//     one beat 0xA5/last=1, beat_cnt=1, frame_cnt=1, level returns to 0.
//   - Backpressure: push 0x01..0x05 with in_ready=0 -> in_valid=1, data=0x01 held,
//     level=5. Then raise in_ready -> 5 back-to-back beats in order, no bubbles.
//   - Overflow: push DEPTH+2 bytes with in_ready=0 -> full=1, ovf=1, level=16,
//     first 16 bytes delivered later.
//   - Full plus pop: level=16, push while popping -> push accepted, ovf stays 0.
//   - Hold: hold=1, push 3 bytes -> in_valid=0. Clear hold -> 3 beats.
//     Set hold while in_valid=1 and in_ready=0 -> beat stays presented until taken.
//   - Clear: level=7, clear strobe with in_ready=1 in the same cycle -> level=0,
//     ovf=0, counters=0, no beat counted.

Source files
------------

// File: rtl/dbg_emio_insig_if.sv
// Byte stream from the EMIO stimulus FIFO to the accelerator input.
// master drives data/last/valid and receives ready; slave is the accelerator side.
interface dbg_emio_insig_if;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;

    modport master (
        output in_data,
        output in_last,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_last,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/dbg_emio_insig.sv
// Debug stimulus source. Software pokes bytes through the EMIO GPIO word and
// toggles a push strobe for each one. The bytes are queued in a small FIFO and
// played out as a valid/ready/last stream. Level, flags and counters are
// reflected back on to_gpio so software can poll progress.
module dbg_emio_insig #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [63:0]            from_gpio,
    output logic [63:0]            to_gpio,
    dbg_emio_insig_if.master       in_if
);

    // ------------------------------------------------------------------
    // Types and constants
    // ------------------------------------------------------------------
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_e;

    localparam logic [AW:0]   LVL_ZERO  = '0;
    localparam logic [AW:0]   LVL_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [63:0]   GPIO_RST  = 64'h0000_0000_0000_0400;

    // GPIO word fields
    localparam int B_PUSH  = 9;
    localparam int B_CLEAR = 10;
    localparam int B_HOLD  = 11;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    // Only the low 12 bits of the GPIO word carry meaning.
    logic         unused_gpio_hi;
    assign unused_gpio_hi = ^from_gpio[63:12];

    logic [11:0]  g_q,  g_d;
    logic [11:0]  g_q2, g_q2_d;
    logic         sync_ok_q, sync_ok_d;

    logic         push_p;
    logic         clear_p;
    logic         hold;
    logic [8:0]   wentry;

    logic [8:0]   mem [DEPTH];
    logic [8:0]   head;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q,  level_d;
    logic          ovf_q,    ovf_d;
    logic [15:0]   beat_cnt_q,  beat_cnt_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic [63:0]   to_gpio_q,   to_gpio_d;

    logic          do_write;
    logic          do_pop;
    logic          pop_req;
    logic          in_valid;

    state_e        state_q, state_d;

    // ------------------------------------------------------------------
    // GPIO capture and strobe edge detection
    // ------------------------------------------------------------------
    // The first edge after reset loads both capture stages with the same
    // sample, so a strobe bit that is already high does not look like a rising
    // edge and cannot fire a push or clear out of reset.
    always_comb begin
        g_d       = from_gpio[11:0];
        g_q2_d    = sync_ok_q ? g_q : from_gpio[11:0];
        sync_ok_d = 1'b1;
    end

    assign push_p  = g_q[B_PUSH]  & ~g_q2[B_PUSH];
    assign clear_p = g_q[B_CLEAR] & ~g_q2[B_CLEAR];
    assign hold    = g_q[B_HOLD];
    assign wentry  = g_q[8:0];

    // ------------------------------------------------------------------
    // Stream outputs: head of the FIFO, valid from the registered state
    // ------------------------------------------------------------------
    assign head           = mem[rd_ptr_q];
    assign in_valid       = (state_q == ST_PRESENT);
    assign in_if.in_valid = in_valid;
    assign in_if.in_data  = head[7:0];
    assign in_if.in_last  = head[8];
    assign pop_req        = in_valid & in_if.in_ready;

    // ------------------------------------------------------------------
    // FIFO bookkeeping, overflow flag and beat/frame counters
    // ------------------------------------------------------------------
    // Clear wins over everything in its cycle: no write, no pop, no count.
    // A push into a full FIFO still lands if the head leaves in the same cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        ovf_d       = ovf_q;
        beat_cnt_d  = beat_cnt_q;
        frame_cnt_d = frame_cnt_q;
        do_write    = 1'b0;
        do_pop      = 1'b0;

        if (clear_p) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = LVL_ZERO;
            ovf_d       = 1'b0;
            beat_cnt_d  = '0;
            frame_cnt_d = '0;
        end else begin
            do_pop   = pop_req;
            do_write = push_p & ((level_q != LVL_FULL) | pop_req);

            if (push_p && (level_q == LVL_FULL) && !pop_req) begin
                ovf_d = 1'b1;
            end

            if (do_write) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end

            if (do_pop) begin
                rd_ptr_d   = rd_ptr_q + PTR_ONE;
                beat_cnt_d = beat_cnt_q + 16'd1;
                if (head[8]) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end

            unique case ({do_write, do_pop})
                2'b10:   level_d = level_q + LVL_ONE;
                2'b01:   level_d = level_q - LVL_ONE;
                default: level_d = level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output state machine: next state
    // ------------------------------------------------------------------
    // While presenting, hold only matters when a beat is taken; after a pop
    // the next head follows without a bubble if more data is (or is becoming)
    // available and hold is low.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!clear_p && (level_q != LVL_ZERO) && !hold) begin
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (clear_p) begin
                    state_d = ST_IDLE;
                end else if (in_if.in_ready) begin
                    if (!hold && ((level_q > LVL_ONE) || push_p)) begin
                        state_d = ST_PRESENT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Status word, one cycle behind the internal state
    // ------------------------------------------------------------------
    always_comb begin
        to_gpio_d = {16'h0000,
                     frame_cnt_q,
                     beat_cnt_q,
                     3'b000,
                     in_valid,
                     ovf_q,
                     (level_q == LVL_ZERO),
                     (level_q == LVL_FULL),
                     9'(level_q)};
    end

    assign to_gpio = to_gpio_q;

    // ------------------------------------------------------------------
    // Control and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples the pre-edge value of its neighbours.
        if (reset) begin
            g_q         <= '0;
            g_q2        <= '0;
            sync_ok_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= LVL_ZERO;
            ovf_q       <= 1'b0;
            beat_cnt_q  <= '0;
            frame_cnt_q <= '0;
            state_q     <= ST_IDLE;
            to_gpio_q   <= GPIO_RST;
        end else begin
            g_q         <= g_d;
            g_q2        <= g_q2_d;
            sync_ok_q   <= sync_ok_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            beat_cnt_q  <= beat_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            state_q     <= state_d;
            to_gpio_q   <= to_gpio_d;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage write port
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; pointers and level define which
    // entries are meaningful, so stale contents are never presented.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr_q] <= wentry;
        end
    end

endmodule
